mul_seq_param: RTL
==================

Name: mul_seq_param

Overview:
- Parametrised sequential shift-add multiplier. Successor to the fixed 16-bit start/data_in/done multiplier.
- Operands arrive over one shared data_in bus on two consecutive cycles: A with start, then B.
- Adds configurable width, a per-operation signed/unsigned mode, a full-width registered product output, a busy flag and an asynchronous reset.
- Sits beside the datapath controllers as a low-area multiply resource.

Parameters:
- WIDTH, 16, operand width in bits (>=2); product is 2*WIDTH bits.
- SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, unsigned only.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE; data_in carries A in the same cycle.
- signed_mode  input  1  sampled with start; 1 = two's-complement operands.
- data_in  input  WIDTH  operand bus: A in the start cycle, B in the following cycle.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  result, held until the next done.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state = IDLE; busy = 0; done = 0; product = 0; counters and operand registers cleared.
- States: IDLE, LOAD_B, CALC, SIGN.
- IDLE:
  - start=1 at edge k captures A and signed_mode (forced 0 if SIGNED_EN=0) -> LOAD_B.
  - done is registered and low in IDLE, except in the single cycle immediately after SIGN.
- LOAD_B:
  - Edge k+1 captures B unconditionally, regardless of start.
  - Signed mode: store |A|, |B| as WIDTH-bit magnitudes and neg_flag = sign(A) xor sign(B).
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned in WIDTH bits.
  - Clear accumulator; count = 0 -> CALC.
- CALC (edges k+2 .. k+WIDTH+1, exactly WIDTH cycles):
  - If multiplier LSB = 1, add the multiplicand into the upper half of the {acc, multiplier} register (WIDTH+1-bit add with carry kept).
  - Shift the register right by 1; count++.
  - When count = WIDTH-1, -> SIGN.
- SIGN (edge k+WIDTH+2):
  - product <= neg_flag ? two's-complement negation of the 2W-bit result : the result.
  - done <= 1; busy <= 0; -> IDLE.
- Latency:
  - done and the new product are visible in the cycle after edge k+WIDTH+2, i.e. WIDTH+2 clock edges after the start edge.
  - Every operation has the same latency; no early exit on zero operands.
- busy = 1 in LOAD_B, CALC and SIGN.
- start while busy is ignored; no queueing. Operand bus contents are don't-care outside the start and LOAD_B cycles.
- start in the done cycle: state is IDLE, so it is accepted; done still drops the next cycle.
- product changes only at SIGN; it is held through the following operation's LOAD_B and CALC.
- Unsigned mode: product = A*B, exact, no overflow possible.
- Signed mode: product = A*B as a 2W-bit two's-complement value, exact for all inputs including (-2^(W-1))^2 = 2^(2W-2).
- rst asserted mid-operation: immediate abort to the reset values. No done is issued for the aborted operation.

Decomposition:
- Package mul_pkg:
  - state enum typedef (IDLE, LOAD_B, CALC, SIGN);
  - function for counter width, $clog2(WIDTH).
- One natural sub-module, mul_seq_ctrl:
  - owns the FSM, counter, busy and done;
  - mul_seq_param holds the datapath (operand registers, adder/shift register, sign fix) and instantiates it.

Test Plan:
- WIDTH=16, unsigned: start with data_in=15, next cycle 15 -> done exactly 18 edges after the start edge, product=225; busy high for 18 cycles.
- Unsigned 15*5 issued in the done cycle of the previous operation -> accepted; product=75 after 18 more edges; previous 225 held until then.
- signed_mode=1:
  - -3*7 -> product=0xFFFFFFEB;
  - -32768 * -32768 -> 0x40000000;
  - SIGNED_EN=0 build with the same operands treats them as unsigned: 0xFFFD*0x0007 -> 0x0006FFEB.
- Unsigned 0xFFFF*0xFFFF -> 0xFFFE0001; 0*0x1234 -> 0 with full 18-edge latency.
- start pulsed during CALC with different data -> ignored; the original product is unaffected; exactly one done.
- rst asserted during CALC:
  - busy, done and product go to 0 asynchronously and no done follows;
  - a new 15*15 after reset release -> 225.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_B,
        CALC,
        SIGN
    } state_t;

    // Bit count large enough to index WIDTH CALC iterations (0 .. WIDTH-1).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequencer for mul_seq_param: FSM, iteration counter, busy and done.
// Decoded strobes tell the datapath which register update to perform.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic load_a,
    output logic load_b,
    output logic calc,
    output logic fix,
    output logic busy,
    output logic done
);

    localparam int CW = cnt_width(WIDTH);

    state_t        state;
    logic [CW-1:0] count;

    assign load_a = (state == IDLE) && start;
    assign load_b = (state == LOAD_B);
    assign calc   = (state == CALC);
    assign fix    = (state == SIGN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_B;
                        busy  <= 1'b1;
                    end
                end
                LOAD_B: begin
                    count <= '0;
                    state <= CALC;
                end
                CALC: begin
                    count <= count + 1'b1;
                    // Fixed WIDTH iterations; zero operands do not exit early.
                    if (count == CW'(WIDTH - 1))
                        state <= SIGN;
                end
                SIGN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mul_seq_param.sv
// Parametrised sequential shift-add multiplier; operands A then B on data_in.
// Signed operands are multiplied as magnitudes and the sign is fixed at the end.
module mul_seq_param
    import mul_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic load_a, load_b, calc, fix;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic             smode;
    logic             neg;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    mul_seq_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .load_a (load_a),
        .load_b (load_b),
        .calc   (calc),
        .fix    (fix),
        .busy   (busy),
        .done   (done)
    );

    // Negating -2^(WIDTH-1) yields the same bit pattern, read as unsigned 2^(WIDTH-1).
    assign a_mag = (smode && mcand[WIDTH-1])   ? -mcand   : mcand;
    assign b_mag = (smode && data_in[WIDTH-1]) ? -data_in : data_in;

    assign sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            smode   <= 1'b0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            if (load_a) begin
                mcand <= data_in;
                smode <= (SIGNED_EN != 0) && signed_mode;
            end
            if (load_b) begin
                mcand  <= a_mag;
                mplier <= b_mag;
                neg    <= smode && (mcand[WIDTH-1] ^ data_in[WIDTH-1]);
                acc    <= '0;
            end
            if (calc) begin
                acc    <= sum[WIDTH:1];
                mplier <= {sum[0], mplier[WIDTH-1:1]};
            end
            if (fix)
                product <= neg ? -{acc, mplier} : {acc, mplier};
        end
    end

endmodule
